timekeeper_core: RTL
====================

TIMEKEEPER_CORE -- requirements
Module: timekeeper_core

Interface
REQ-001 SHALL provide parameter CLK_HZ, default 100_000_000, input clock frequency; one-second tick period in cycles.
REQ-002 SHALL provide parameter ALARM_SECS, default 30, maximum alarm ring duration in seconds (1..255).
REQ-003 SHALL have one clock and an asynchronous, active-high reset, with ports as follows:
- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous active-high reset.
- en, input, 1: run enable.
- hrup / hrdn, input, 1 each: hour up / hour down buttons (synchronous to clk).
- minup / mindn, input, 1 each: minute up / minute down buttons.
- mode12, input, 1: 1 selects 12-hour display, 0 selects 24-hour display.
- tick_o, output, 1: one-cycle pulse each elapsed second.
- s1, s2, m1, m2, h1, h2, output, 4 each: BCD ones/tens digits of seconds, minutes and hours.
- pm, output, 1: hour is 12..23.
- al_set, al_en, al_ack, input, 1 each (ALARM_EN only): redirect set buttons to alarm; arm alarm; acknowledge alarm.
- alarm_o, output, 1 (ALARM_EN only): alarm ringing.

Function
REQ-004 Prescaler SHALL count 0..CLK_HZ-1 while en=1; tick on the count==CLK_HZ-1 cycle, then wrap to 0; period exactly CLK_HZ cycles.
REQ-005 en=0 SHALL freeze prescaler and time; set buttons SHALL remain active.
REQ-006 On tick: sec 59 wraps to 0 and carries to min; min 59 wraps to 0 and carries to hour; hour 23 wraps to 0. tick_o SHALL pulse in the same cycle.
REQ-007 Each button SHALL act once per press, on its rising edge (registered previous value); holding a button SHALL have no further effect.
REQ-008 Minute set SHALL apply ±1 modulo 60 with no carry to hour, and SHALL clear sec and prescaler to 0.
REQ-009 Hour set SHALL apply ±1 modulo 24 and leave min, sec and prescaler unchanged.
REQ-010 Priority SHALL be rst > minute edge > hour edge > tick; a tick coinciding with any set edge SHALL be discarded (tick_o still pulses).
REQ-011 Simultaneous up and down edges on the same field SHALL leave that field unchanged; for minutes the sec/prescaler clear SHALL still apply.
REQ-012 Digit outputs and pm SHALL be registered, reflecting internal state with one-cycle latency.
REQ-013 mode12=1 SHALL display hours as follows: internal 0 shows 12; 1..12 show unchanged; 13..23 show minus 12. mode12=0 SHALL display 0..23. pm is independent of mode.
REQ-014 Internal counters SHALL be 6 bits wide, with comparisons against 59 and 23 only; no out-of-range value is reachable.

Reset
REQ-015 rst SHALL asynchronously clear hour, min, sec, prescaler, button-edge registers, all digit outputs, pm, tick_o and (ALARM_EN) alarm time, alarm state and alarm_o to 0.
REQ-016 Reset asserted mid-second SHALL discard the partial prescaler count; the first tick SHALL occur CLK_HZ cycles after release with en=1.

Configuration
REQ-017 Macro TIMEKEEPER_ALARM_EN defined SHALL compile in the alarm ports, alarm hour/min registers and an alarm FSM.
- With al_set=1, set buttons SHALL modify the alarm time (same modulo rules, no sec clear) instead of the time.
- The FSM SHALL use states ALM_IDLE and ALM_RING.
- ALM_IDLE→ALM_RING SHALL occur on a tick producing hh:mm:00 equal to the alarm time while al_en=1.
- ALM_RING→ALM_IDLE SHALL occur on al_ack, al_en=0, or after ALARM_SECS ticks; al_ack SHALL win over a same-cycle match.
- alarm_o SHALL be 1 exactly in ALM_RING.
REQ-018 Macro undefined SHALL omit those ports and logic entirely; al_set behaviour is absent.

Structure
REQ-019 Package timekeeper_pkg SHALL hold SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23, typedef bcd_t (4 bits) and typedef alm_state_t.
REQ-020 Sub-module bin2bcd_2d SHALL convert 0..59 to two bcd_t digits; timekeeper_core SHALL instantiate it three times.

Verification (CLK_HZ=10)
REQ-021 Release rst, en=1, wait 10 cycles -> one tick_o; s1=1 one cycle later; all other digits 0.
REQ-022 Preload 23:59:59, one tick -> 00:00:00; pm goes 1→0.
REQ-023 Hold minup high 50 cycles at 00:05:07 -> exactly 00:06:00; prescaler restarted.
REQ-024 hrup and hrdn rising in the same cycle at 07:xx -> hour stays 7; mindn at min 0 -> 59 with no hour change.
REQ-025 mode12=1 at hour 0, 12, 13 -> h2h1 = 12, 12, 01; pm = 0, 1, 1.
REQ-026 ALARM_EN, alarm 00:01, al_en=1, run from 00:00:59 -> alarm_o rises with the tick; al_ack -> low next cycle; without al_ack -> low after 30 ticks.

Source files
------------

// File: rtl/timekeeper_pkg.sv
// Shared limits, digit/state types and the +/-1 wrap helper for the timekeeper.
// Pure declarations; no logic, no latency.
package timekeeper_pkg;

  localparam logic [5:0] SEC_MAX  = 6'd59;
  localparam logic [5:0] MIN_MAX  = 6'd59;
  localparam logic [5:0] HOUR_MAX = 6'd23;

  typedef logic [3:0] bcd_t;

  typedef enum logic {
    ALM_IDLE = 1'b0,
    ALM_RING = 1'b1
  } alm_state_t;

  // Up and down together cancel, leaving the field untouched.
  function automatic logic [5:0] step_mod(input logic [5:0] v, input logic [5:0] lim,
                                          input logic up, input logic dn);
    if (up && !dn) begin
      return (v == lim) ? 6'd0 : v + 6'd1;
    end else if (dn && !up) begin
      return (v == 6'd0) ? lim : v - 6'd1;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/bin2bcd_2d.sv
// Combinational binary (0..59) to two BCD digits.
// Zero latency, no flow control.
module bin2bcd_2d
  import timekeeper_pkg::*;
(
  input  logic [5:0] bin_i,
  output bcd_t       tens_o,
  output bcd_t       ones_o
);

  always_comb begin
    tens_o = 4'd0;
    ones_o = bin_i[3:0];
    if (bin_i >= 6'd50) begin
      tens_o = 4'd5;
      ones_o = 4'(bin_i - 6'd50);
    end else if (bin_i >= 6'd40) begin
      tens_o = 4'd4;
      ones_o = 4'(bin_i - 6'd40);
    end else if (bin_i >= 6'd30) begin
      tens_o = 4'd3;
      ones_o = 4'(bin_i - 6'd30);
    end else if (bin_i >= 6'd20) begin
      tens_o = 4'd2;
      ones_o = 4'(bin_i - 6'd20);
    end else if (bin_i >= 6'd10) begin
      tens_o = 4'd1;
      ones_o = 4'(bin_i - 6'd10);
    end
  end

endmodule

// File: rtl/timekeeper_core.sv
// 24h clock with 1 s prescaler, edge-triggered set buttons and optional alarm (TIMEKEEPER_ALARM_EN).
// Digits/pm registered one cycle after state; tick_o same cycle; no backpressure.
module timekeeper_core
  import timekeeper_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int ALARM_SECS = 30
)(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic hrup,
  input  logic hrdn,
  input  logic minup,
  input  logic mindn,
  input  logic mode12,
`ifdef TIMEKEEPER_ALARM_EN
  input  logic al_set,
  input  logic al_en,
  input  logic al_ack,
  output logic alarm_o,
`endif
  output logic tick_o,
  output bcd_t s1,
  output bcd_t s2,
  output bcd_t m1,
  output bcd_t m2,
  output bcd_t h1,
  output bcd_t h2,
  output logic pm
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);

  if (ALARM_SECS < 1 || ALARM_SECS > 255) begin : g_bad_alarm_secs
    $error("ALARM_SECS out of range");
  end

  logic [PW-1:0] presc_q, presc_d;
  logic [5:0]    sec_q, sec_d, min_q, min_d, hour_q, hour_d;
  logic [3:0]    btn_q, btn_d, btn_rise;
  bcd_t          s1_q, s1_d, s2_q, s2_d, m1_q, m1_d, m2_q, m2_d, h1_q, h1_d, h2_q, h2_d;
  logic          pm_q, pm_d;
  logic [5:0]    disp_hour;
  logic          tick, to_time, time_min_edge, time_hr_edge;

  // Bit order: minup, mindn, hrup, hrdn.
  assign btn_d    = {minup, mindn, hrup, hrdn};
  assign btn_rise = btn_d & ~btn_q;
  assign tick     = en && (presc_q == PRESC_LAST);
  assign tick_o   = tick;

`ifdef TIMEKEEPER_ALARM_EN
  assign to_time = ~al_set;
`else
  assign to_time = 1'b1;
`endif
  assign time_min_edge = to_time & (btn_rise[3] | btn_rise[2]);
  assign time_hr_edge  = to_time & (btn_rise[1] | btn_rise[0]);

  always_comb begin
    presc_d = presc_q;
    sec_d   = sec_q;
    min_d   = min_q;
    hour_d  = hour_q;
    if (en) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
    end
    if (time_min_edge) begin
      min_d   = step_mod(min_q, MIN_MAX, btn_rise[3], btn_rise[2]);
      sec_d   = 6'd0;
      presc_d = '0;
    end else if (time_hr_edge) begin
      hour_d = step_mod(hour_q, HOUR_MAX, btn_rise[1], btn_rise[0]);
    end else if (tick) begin
      if (sec_q == SEC_MAX) begin
        sec_d = 6'd0;
        if (min_q == MIN_MAX) begin
          min_d  = 6'd0;
          hour_d = (hour_q == HOUR_MAX) ? 6'd0 : hour_q + 6'd1;
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end
  end

  always_comb begin
    disp_hour = hour_q;
    if (mode12) begin
      if (hour_q == 6'd0) begin
        disp_hour = 6'd12;
      end else if (hour_q > 6'd12) begin
        disp_hour = hour_q - 6'd12;
      end
    end
    pm_d = (hour_q >= 6'd12);
  end

  bin2bcd_2d u_sec  (.bin_i(sec_q),     .tens_o(s2_d), .ones_o(s1_d));
  bin2bcd_2d u_min  (.bin_i(min_q),     .tens_o(m2_d), .ones_o(m1_d));
  bin2bcd_2d u_hour (.bin_i(disp_hour), .tens_o(h2_d), .ones_o(h1_d));

`ifdef TIMEKEEPER_ALARM_EN
  localparam logic [7:0] RING_LAST = 8'(ALARM_SECS - 1);

  logic [5:0] alm_min_q, alm_min_d, alm_hour_q, alm_hour_d;
  logic [7:0] ring_cnt_q;
  alm_state_t alm_state_q;
  logic       alarm_q, tick_adv, match;

  always_comb begin
    alm_min_d  = alm_min_q;
    alm_hour_d = alm_hour_q;
    if (al_set) begin
      if (btn_rise[3] | btn_rise[2]) begin
        alm_min_d = step_mod(alm_min_q, MIN_MAX, btn_rise[3], btn_rise[2]);
      end else if (btn_rise[1] | btn_rise[0]) begin
        alm_hour_d = step_mod(alm_hour_q, HOUR_MAX, btn_rise[1], btn_rise[0]);
      end
    end
  end

  // Only a tick that actually advances the time can land on hh:mm:00.
  assign tick_adv = tick & ~time_min_edge & ~time_hr_edge;
  assign match    = al_en && tick_adv && (sec_d == 6'd0) &&
                    (min_d == alm_min_q) && (hour_d == alm_hour_q);
  assign alarm_o  = alarm_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alm_state_q <= ALM_IDLE;
      ring_cnt_q  <= 8'd0;
      alarm_q     <= 1'b0;
      alm_min_q   <= 6'd0;
      alm_hour_q  <= 6'd0;
    end else begin
      alm_min_q  <= alm_min_d;
      alm_hour_q <= alm_hour_d;
      unique case (alm_state_q)
        ALM_IDLE: begin
          if (match && !al_ack) begin
            alm_state_q <= ALM_RING;
            ring_cnt_q  <= 8'd0;
            alarm_q     <= 1'b1;
          end
        end
        ALM_RING: begin
          if (al_ack || !al_en || (tick && ring_cnt_q == RING_LAST)) begin
            alm_state_q <= ALM_IDLE;
            alarm_q     <= 1'b0;
          end else if (tick) begin
            ring_cnt_q <= ring_cnt_q + 8'd1;
          end
        end
      endcase
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      sec_q   <= 6'd0;
      min_q   <= 6'd0;
      hour_q  <= 6'd0;
      btn_q   <= 4'd0;
      s1_q    <= 4'd0;
      s2_q    <= 4'd0;
      m1_q    <= 4'd0;
      m2_q    <= 4'd0;
      h1_q    <= 4'd0;
      h2_q    <= 4'd0;
      pm_q    <= 1'b0;
    end else begin
      presc_q <= presc_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hour_q  <= hour_d;
      btn_q   <= btn_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      m1_q    <= m1_d;
      m2_q    <= m2_d;
      h1_q    <= h1_d;
      h2_q    <= h2_d;
      pm_q    <= pm_d;
    end
  end

  assign s1 = s1_q;
  assign s2 = s2_q;
  assign m1 = m1_q;
  assign m2 = m2_q;
  assign h1 = h1_q;
  assign h2 = h2_q;
  assign pm = pm_q;

endmodule
